reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter ADDR, default 5, meaning register address width.
REQ-002 SHALL have parameter NREGS, default 32, meaning number of architectural registers (2**ADDR).
REQ-003 SHALL have parameter CNTW, default 2, meaning per-register pending-write counter width (max 3 outstanding per register).
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk input 1, the single clock; rst_n input 1, the asynchronous active-low reset.
REQ-005 SHALL have port issue_valid input 1, meaning decode presents an instruction.
REQ-006 SHALL have port issue_ready output 1, meaning the scoreboard accepts the instruction this cycle.
REQ-007 SHALL have ports issue_rs1_addr and issue_rs2_addr, input ADDR each, meaning source register addresses.
REQ-008 SHALL have ports issue_rs1_used and issue_rs2_used, input 1 each, meaning the source is actually read.
REQ-009 SHALL have port issue_rd_addr input ADDR, meaning destination register.
REQ-010 SHALL have port issue_rd_wr input 1, meaning the instruction writes rd.
REQ-011 SHALL have port wb_write_en input 1, meaning writeback commits a write this cycle.
REQ-012 SHALL have port wb_rd_addr input ADDR, meaning the writeback destination.
REQ-013 SHALL have port flush input 1, meaning a synchronous pipeline flush.
REQ-014 SHALL have port busy_vec output NREGS, meaning bit i is set when register i has pending writes.
REQ-015 SHALL have port pend_total output 7, meaning the registered total of outstanding writes.
REQ-016 SHALL have port err_underflow output 1, meaning a sticky flag for a writeback to a register with no pending write.

Function
REQ-017 SHALL keep a CNTW-bit pending counter per register 1..NREGS-1; register 0 has no counter and busy_vec[0] is always 0.
REQ-018 SHALL define accept = issue_valid && issue_ready.
REQ-019 SHALL define hazard as any of:
- issue_rs1_used, issue_rs1_addr!=0 and pend[rs1]!=0;
- the same condition for rs2;
- issue_rd_wr, issue_rd_addr!=0 and pend[rd]==max (saturation).
REQ-020 SHALL drive issue_ready = !flush && !hazard, combinationally, using counter state before the current edge; there is no same-cycle writeback bypass.
REQ-021 SHALL raise issue_ready regardless of issue_valid; issue_ready SHALL NOT depend on issue_valid.
REQ-022 SHALL increment pend[rd] on accept && issue_rd_wr && issue_rd_addr!=0.
REQ-023 SHALL decrement pend[wb_rd_addr] on wb_write_en && wb_rd_addr!=0 && pend[wb_rd_addr]!=0.
REQ-024 SHALL leave a counter unchanged when increment and decrement target the same register in the same cycle.
REQ-025 SHALL ignore wb_write_en with wb_rd_addr==0 entirely, with no error.
REQ-026 SHALL, for wb_write_en to a nonzero register with pend==0, leave counters unchanged and set err_underflow; the flag is cleared only by reset.
REQ-027 SHALL update pend_total by +1 and/or -1 per the counted events in the same cycle; simultaneous +1 and -1 leaves it unchanged.
REQ-028 SHALL, on flush, zero all counters and pend_total at the next edge; flush overrides issue and writeback that cycle.
REQ-029 SHALL NOT let flush clear err_underflow.
REQ-030 SHALL drive busy_vec[i] = (pend[i]!=0) from registered state; it is combinational from the counters only.
REQ-031 SHALL evaluate a hazard on rs equal to rd of the same instruction against pre-issue state only.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously clear all counters, pend_total and err_underflow; busy_vec then reads 0.
REQ-033 SHALL, while rst_n=0, drive issue_ready per REQ-020 from cleared state, which is 1 unless flush is asserted.
REQ-034 SHALL, on reset assertion mid-operation, discard all pending state with no recovery; the first edge after deassertion behaves as from empty.

Verification
REQ-035 SHALL cover issue rd=5 with rd_wr=1 and valid=1 -> next cycle busy_vec[5]=1, pend_total=1; then issue rs1=5 with used=1 -> issue_ready=0; then wb_rd_addr=5 -> next cycle busy_vec[5]=0 and issue_ready=1.
REQ-036 SHALL cover three accepted issues to rd=7 -> pend[7]=3 and pend_total=3; a fourth issue to rd=7 -> issue_ready=0 until one writeback to 7 occurs.
REQ-037 SHALL cover a same-cycle accepted issue rd=9 and writeback to 9 with pend[9]=1 -> pend[9] stays 1, pend_total unchanged.
REQ-038 SHALL cover writeback to 12 with pend[12]=0 -> err_underflow=1, counters unchanged; flush -> err_underflow remains 1.
REQ-039 SHALL cover issue rd=0 and writeback rd=0 -> no counter change and err_underflow stays 0; rs1=0 with used=1 never stalls.
REQ-040 SHALL cover pend_total=4 then flush with simultaneous valid issue -> issue_ready=0, next cycle busy_vec=0 and pend_total=0; reset mid-run clears all.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters with
// issue hazard detection, writeback retire and flush/underflow tracking.
module reg_scoreboard #(
  parameter int ADDR  = 5,
  parameter int NREGS = 32,
  parameter int CNTW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [ADDR-1:0]  issue_rs1_addr,
  input  logic [ADDR-1:0]  issue_rs2_addr,
  input  logic             issue_rs1_used,
  input  logic             issue_rs2_used,
  input  logic [ADDR-1:0]  issue_rd_addr,
  input  logic             issue_rd_wr,
  input  logic             wb_write_en,
  input  logic [ADDR-1:0]  wb_rd_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec,
  output logic [6:0]       pend_total,
  output logic             err_underflow
);

  localparam logic [CNTW-1:0] PMAX = '1;

  logic [CNTW-1:0]  pend [NREGS];
  logic             hz_rs1;
  logic             hz_rs2;
  logic             hz_rd;
  logic             accept;
  logic             inc_ev;
  logic             dec_ev;
  logic             und_ev;
  logic [NREGS-1:0] inc_vec;
  logic [NREGS-1:0] dec_vec;

  always_comb begin
    hz_rs1 = issue_rs1_used
          && (issue_rs1_addr != '0)
          && (pend[issue_rs1_addr] != '0);
    hz_rs2 = issue_rs2_used
          && (issue_rs2_addr != '0)
          && (pend[issue_rs2_addr] != '0);
    hz_rd  = issue_rd_wr
          && (issue_rd_addr != '0)
          && (pend[issue_rd_addr] == PMAX);
  end

  assign issue_ready = !flush && !(hz_rs1 || hz_rs2 || hz_rd);
  assign accept      = issue_valid && issue_ready;

  // Writebacks only count against a register that really has a pending write.
  always_comb begin
    inc_ev  = accept && issue_rd_wr && (issue_rd_addr != '0);
    dec_ev  = wb_write_en && (wb_rd_addr != '0)
           && (pend[wb_rd_addr] != '0);
    und_ev  = wb_write_en && (wb_rd_addr != '0)
           && (pend[wb_rd_addr] == '0) && !flush;
    inc_vec = '0;
    dec_vec = '0;
    if (inc_ev) inc_vec[issue_rd_addr] = 1'b1;
    if (dec_ev) dec_vec[wb_rd_addr]    = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) pend[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREGS; i++) pend[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          pend[i] <= pend[i] + CNTW'(1);
        else if (dec_vec[i] && !inc_vec[i])
          pend[i] <= pend[i] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_total <= '0;
    end else if (flush) begin
      pend_total <= '0;
    end else if (inc_ev && !dec_ev) begin
      pend_total <= pend_total + 7'd1;
    end else if (dec_ev && !inc_ev) begin
      pend_total <= pend_total - 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_underflow <= 1'b0;
    else if (und_ev) err_underflow <= 1'b1;
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NREGS; i++)
      busy_vec[i] = (pend[i] != '0);
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus
// randomized traffic against an array-based pending-write model.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1_addr;
  logic [4:0]  issue_rs2_addr;
  logic        issue_rs1_used;
  logic        issue_rs2_used;
  logic [4:0]  issue_rd_addr;
  logic        issue_rd_wr;
  logic        wb_write_en;
  logic [4:0]  wb_rd_addr;
  logic        flush;
  logic [31:0] busy_vec;
  logic [6:0]  pend_total;
  logic        err_underflow;

  reg_scoreboard dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs1_addr (issue_rs1_addr),
    .issue_rs2_addr (issue_rs2_addr),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2_used (issue_rs2_used),
    .issue_rd_addr  (issue_rd_addr),
    .issue_rd_wr    (issue_rd_wr),
    .wb_write_en    (wb_write_en),
    .wb_rd_addr     (wb_rd_addr),
    .flush          (flush),
    .busy_vec       (busy_vec),
    .pend_total     (pend_total),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int pm [32];
  int tot;
  bit err;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    bit hz;
    hz = (issue_rs1_used && issue_rs1_addr != 0
          && pm[issue_rs1_addr] > 0)
      || (issue_rs2_used && issue_rs2_addr != 0
          && pm[issue_rs2_addr] > 0)
      || (issue_rd_wr && issue_rd_addr != 0
          && pm[issue_rd_addr] == 3);
    return !flush && !hz;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int i = 1; i < 32; i++) b[i] = (pm[i] > 0);
    return b;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) pm[i] = 0;
    tot = 0;
  endtask

  task automatic drive(input bit v,
                       input int r1, input bit u1,
                       input int r2, input bit u2,
                       input int rd, input bit w,
                       input bit wbe, input int wbr,
                       input bit fl);
    issue_valid    = v;
    issue_rs1_addr = 5'(r1);
    issue_rs1_used = u1;
    issue_rs2_addr = 5'(r2);
    issue_rs2_used = u2;
    issue_rd_addr  = 5'(rd);
    issue_rd_wr    = w;
    wb_write_en    = wbe;
    wb_rd_addr     = 5'(wbr);
    flush          = fl;
  endtask

  // One clock: drive, compare pre-edge outputs, advance model past the edge.
  task automatic step(input bit v,
                      input int r1, input bit u1,
                      input int r2, input bit u2,
                      input int rd, input bit w,
                      input bit wbe, input int wbr,
                      input bit fl);
    bit rdy;
    @(negedge clk);
    drive(v, r1, u1, r2, u2, rd, w, wbe, wbr, fl);
    #1;
    rdy = m_ready();
    check("issue_ready", 64'(issue_ready), 64'(rdy));
    check("busy_vec", 64'(busy_vec), 64'(m_busy()));
    check("pend_total", 64'(pend_total), 64'(tot));
    check("err_underflow", 64'(err_underflow), 64'(err));
    @(posedge clk);
    if (fl) begin
      m_clear();
    end else begin
      if (wbe && wbr != 0) begin
        if (pm[wbr] > 0) begin
          pm[wbr]--;
          tot--;
        end else begin
          err = 1;
        end
      end
      if (v && rdy && w && rd != 0) begin
        pm[rd]++;
        tot++;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_clear();
    err = 0;
    #1;
    check("rst_busy", 64'(busy_vec), 64'(0));
    check("rst_total", 64'(pend_total), 64'(0));
    check("rst_err", 64'(err_underflow), 64'(0));
    check("rst_ready", 64'(issue_ready), 64'(1));
    flush = 1;
    #1;
    check("rst_ready_fl", 64'(issue_ready), 64'(0));
    flush = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int rd, wbr;
    bit wbe;
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_clear();
    err = 0;
    do_reset();

    // issue rd=5, stall on rs1=5, retire
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    check("busy5_set", 64'(busy_vec[5]), 64'(1));
    check("total_1", 64'(pend_total), 64'(1));
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("raw_stall", 64'(issue_ready), 64'(0));
    step(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    check("busy5_clr", 64'(busy_vec[5]), 64'(0));
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("raw_release", 64'(issue_ready), 64'(1));

    // saturation on rd=7
    repeat (3) step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    check("total_3", 64'(pend_total), 64'(3));
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    check("sat_hold", 64'(pend_total), 64'(3));
    step(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    check("sat_refill", 64'(pend_total), 64'(3));
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);

    // same-cycle issue and writeback on 9
    step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
    check("same9_busy", 64'(busy_vec[9]), 64'(1));
    check("same9_total", 64'(pend_total), 64'(1));
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);

    // x0 is never tracked and never stalls
    step(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    check("x0_err", 64'(err_underflow), 64'(0));
    check("x0_total", 64'(pend_total), 64'(0));

    // underflow on 12, sticky across flush
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    check("uf_set", 64'(err_underflow), 64'(1));
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("uf_sticky", 64'(err_underflow), 64'(1));

    // four pending then flush with a valid issue
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    check("total_4", 64'(pend_total), 64'(4));
    step(1, 0, 0, 0, 0, 6, 1, 1, 1, 1);
    check("fl_busy", 64'(busy_vec), 64'(0));
    check("fl_total", 64'(pend_total), 64'(0));

    // randomized traffic with one mid-run reset
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      rd  = $urandom_range(0, 15);
      wbe = $urandom_range(0, 1);
      wbr = $urandom_range(0, 15);
      if (wbe && tot > 0 && $urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 16; k++) begin
          wbr = $urandom_range(1, 15);
          if (pm[wbr] > 0) break;
        end
      end
      step($urandom_range(0, 1),
           $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom_range(0, 1),
           rd, $urandom_range(0, 3) != 0,
           wbe, wbr, $urandom_range(0, 40) == 0);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
